// File: rtl/alu_cola_ops_if.sv
// Request and result handshakes of the ALU command queue.
// The DUT side uses the slave modport, the producer/consumer side the master.
interface alu_cola_ops_if #(
  parameter int ANCHO = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [ANCHO-1:0] in_a;
  logic [ANCHO-1:0] in_b;
  logic [2:0]       in_sel;
  logic             res_valid;
  logic             res_ready;
  logic [ANCHO-1:0] res_dato;
  logic [2:0]       res_sel;

  modport master (
    output in_valid, in_a, in_b, in_sel, res_ready,
    input  in_ready, res_valid, res_dato, res_sel
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, res_ready,
    output in_ready, res_valid, res_dato, res_sel
  );
endinterface

// File: rtl/alu_cola_ops.sv
// ALU front-end: request FIFO feeding a combinational ALU, result register out.
// ALU_COLA_CHECK_SEL_EN: drop op codes 101/110 and pulse err_sel instead.
module alu_cola_ops #(
  parameter int PROFUNDIDAD = 4,
  parameter int ANCHO       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  alu_cola_ops_if.slave                bus,
  output logic [ANCHO-1:0]             alu_a,
  output logic [ANCHO-1:0]             alu_b,
  output logic [2:0]                   alu_sel,
  output logic                         alu_enable,
  input  logic [ANCHO-1:0]             alu_salida,
  output logic [$clog2(PROFUNDIDAD):0] ocupacion,
  output logic                         err_sel
);
  localparam int PW = $clog2(PROFUNDIDAD);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    logic [2:0]       sel;
  } ent_t;

  ent_t mem_q [PROFUNDIDAD];

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic [ANCHO-1:0] rdat_q, rdat_d;
  logic [2:0]       rsel_q, rsel_d;

  logic hs;
  logic push;
  logic pop;
  logic vacia;

  assign vacia = (cnt_q == '0);
  assign hs    = bus.in_valid && bus.in_ready;
  assign pop   = !vacia && (!rv_q || bus.res_ready);

`ifdef ALU_COLA_CHECK_SEL_EN
  logic bad_sel;
  logic err_q;

  assign bad_sel = (bus.in_sel == 3'b101) || (bus.in_sel == 3'b110);
  assign push    = hs && !bad_sel;
  assign err_sel = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= hs && bad_sel;
  end
`else
  assign push    = hs;
  assign err_sel = 1'b0;
`endif

  assign bus.in_ready  = (cnt_q < CW'(PROFUNDIDAD));
  assign bus.res_valid = rv_q;
  assign bus.res_dato  = rdat_q;
  assign bus.res_sel   = rsel_q;
  assign ocupacion     = cnt_q;
  assign alu_enable    = !vacia;

  // Head is forced to zero when empty so the ALU sees a quiet bus.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!vacia) begin
      alu_a   = mem_q[rd_q].a;
      alu_b   = mem_q[rd_q].b;
      alu_sel = mem_q[rd_q].sel;
    end
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    rv_d   = rv_q;
    rdat_d = rdat_q;
    rsel_d = rsel_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop) begin
      rd_d   = rd_q + PW'(1);
      rv_d   = 1'b1;
      rdat_d = alu_salida;
      rsel_d = alu_sel;
    end else if (bus.res_ready) begin
      rv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      rv_q   <= 1'b0;
      rdat_q <= '0;
      rsel_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      rv_q   <= rv_d;
      rdat_q <= rdat_d;
      rsel_q <= rsel_d;
    end
  end
endmodule

// File: tb/tb_alu_cola_ops.sv
// Scoreboard bench for alu_cola_ops with a behavioural ALU on the alu_* bus.
// Honours ALU_COLA_CHECK_SEL_EN when compiled with it.
module tb_alu_cola_ops;
  localparam int P = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cola_ops_if #(.ANCHO(W)) bus ();

  logic [W-1:0]         alu_a, alu_b, alu_salida;
  logic [2:0]           alu_sel;
  logic                 alu_enable, err_sel;
  logic [$clog2(P):0]   ocupacion;

  alu_cola_ops #(.PROFUNDIDAD(P), .ANCHO(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_enable (alu_enable),
    .alu_salida (alu_salida),
    .ocupacion  (ocupacion),
    .err_sel    (err_sel)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, b,
                                         input logic [2:0] s);
    case (s)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b100:  return ~(a & b);
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b111:  return a * b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_salida = alu_f(alu_a, alu_b, alu_sel);

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [34:0] sb [$];
  int res_cyc [$];

  logic [2:0]  s2 [5] = '{3'b000, 3'b001, 3'b100, 3'b011, 3'b111};
  logic [31:0] e2 [5] = '{32'h00F0_0004, 32'hFFF0_000C, 32'hFF0F_FFFB,
                          32'hE100_0008, 32'h8300_0030};

  task automatic chk(input string tag, input logic [63:0] got, exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      res_cyc.push_back(cyc);
      if (sb.size() == 0) chk("extra_res", 1, 0);
      else chk("res", {bus.res_sel, bus.res_dato}, sb.pop_front());
    end
  end

  task automatic push(input logic [W-1:0] a, b, input logic [2:0] s,
                      input logic [W-1:0] exp);
    int n;
    bit keep;
    n = 0;
    keep = 1'b1;
`ifdef ALU_COLA_CHECK_SEL_EN
    keep = !(s == 3'b101 || s == 3'b110);
`endif
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sel = s;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("push_timeout", 1, 0);
    end else begin
      if (keep) sb.push_back({s, exp});
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, held;
    logic [2:0] s;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sel = '0;
    bus.res_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_valid", bus.res_valid, 0);
    chk("rst_dato", bus.res_dato, 0);
    chk("rst_sel", bus.res_sel, 0);
    chk("rst_ocup", ocupacion, 0);
    chk("rst_err", err_sel, 0);
    chk("rst_en", alu_enable, 0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_rdy", bus.in_ready, 1);

    // single add, latency
    bus.res_ready = 1'b1;
    push(32'd5, 32'd3, 3'b010, 32'd8);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_en", alu_enable, 1);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_v0", bus.res_valid, 0);
    @(negedge clk);
    chk("t1_v1", bus.res_valid, 1);
    chk("t1_dato", bus.res_dato, 32'h8);
    chk("t1_sel", bus.res_sel, 3'b010);
    @(negedge clk);
    chk("t1_v2", bus.res_valid, 0);
    @(posedge clk); #1;

    // back-to-back ops, no bubbles
    res_cyc.delete();
    for (int i = 0; i < 5; i++) push(32'hF0F0_000C, 32'h0FF0_0004, s2[i], e2[i]);
    bus.in_valid = 1'b0;
    drain();
    chk("t2_n", res_cyc.size(), 5);
    if (res_cyc.size() == 5) chk("t2_gap", res_cyc[4] - res_cyc[0], 4);

    // stall: fill to full
    bus.res_ready = 1'b0;
    for (int i = 0; i < P + 1; i++) begin
      a = $urandom; b = $urandom; s = 3'($urandom_range(0, 7));
      if (s == 3'b101 || s == 3'b110) s = 3'b010;
      push(a, b, s, alu_f(a, b, s));
    end
    bus.in_valid = 1'b0;
    held = sb[0][31:0];
    @(negedge clk);
    chk("t3_ocup", ocupacion, P);
    chk("t3_rdy", bus.in_ready, 0);
    chk("t3_v", bus.res_valid, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold", bus.res_dato, held);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    drain();

    // full queue then streaming push+pop
    bus.res_ready = 1'b0;
    for (int i = 0; i < P + 1; i++) begin
      a = $urandom; b = $urandom; s = 3'b011;
      push(a, b, s, alu_f(a, b, s));
    end
    chk("t4_full", bus.in_ready, 0);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = i; s = 3'b111;
      push(a, b, s, alu_f(a, b, s));
      chk("t4_ocup", ocupacion, P - 1);
    end
    bus.in_valid = 1'b0;
    drain();
    idle(3);

    // async reset mid-operation
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h100 + i, 32'h1, 3'b010, 32'h101 + i);
    bus.in_valid = 1'b0;
    chk("t5_ocup", ocupacion, 3);
    chk("t5_v", bus.res_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rv", bus.res_valid, 0);
    chk("t5_ro", ocupacion, 0);
    chk("t5_ren", alu_enable, 0);
    chk("t5_rrdy", bus.in_ready, 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    idle(5);
    chk("t5_stale", bus.res_valid, 0);

    // reserved op code
    push(32'h1234, 32'h5678, 3'b101, 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
`ifdef ALU_COLA_CHECK_SEL_EN
    chk("t6_err", err_sel, 1);
    chk("t6_ocup", ocupacion, 0);
`else
    chk("t6_err", err_sel, 0);
    chk("t6_ocup", ocupacion, 1);
`endif
    @(negedge clk);
    chk("t6_err_off", err_sel, 0);
    @(posedge clk); #1;
    drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_cola_ops.md
# alu_cola_ops

Command queue and result register on the ALU's front side. Accepts operation requests (two 32-bit operands plus 3-bit selector) over a valid/ready handshake and buffers them in a FIFO. It presents the head entry to the combinational ALU and captures the ALU's result into an output register with its own valid/ready handshake. Sustains one operation per cycle when the consumer is ready.

## Interface
- `PROFUNDIDAD`, 4, FIFO depth in entries; power of two, ≥ 2
- `ANCHO`, 32, operand/result width; must match the ALU (32)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  request present
- `in_ready`  out  1  queue can accept (`ocupacion < PROFUNDIDAD`)
- `in_a`, `in_b`  in  ANCHO  operands
- `in_sel`  in  3  ALU op code
- `alu_a`, `alu_b`  out  ANCHO  head operands to ALU
- `alu_sel`  out  3  head op code to ALU
- `alu_enable`  out  1  high when queue non-empty
- `alu_salida`  in  ANCHO  ALU result (combinational from `alu_*`)
- `res_valid`  out  1  result register holds data
- `res_ready`  in  1  consumer takes result
- `res_dato`  out  ANCHO  captured result
- `res_sel`  out  3  op code that produced `res_dato`
- `ocupacion`  out  $clog2(PROFUNDIDAD)+1  entries in queue
- `err_sel`  out  1  one-cycle pulse on rejected request (see Configuration)

## Operation
- Op codes, with ALU behaviour passed through unchanged:
  - 000 AND, 001 OR, 100 NAND, 010 add, 011 subtract, 111 multiply (low 32 bits)
  - 101 and 110 yield 0
- Push: `in_valid && in_ready` at a rising edge writes `{in_a,in_b,in_sel}` at the write pointer. Write pointer increments modulo PROFUNDIDAD.
- Head drive: `alu_a/alu_b/alu_sel` = entry at the read pointer when non-empty; forced to 0 when empty. `alu_enable = (ocupacion != 0)`.
- Pop condition: `ocupacion != 0 && (!res_valid || res_ready)`.
- On pop:
  - `res_dato <= alu_salida`, `res_sel <= alu_sel`, `res_valid <= 1`
  - read pointer increments modulo PROFUNDIDAD
- No pop and `res_ready` high: `res_valid <= 0`; `res_dato`/`res_sel` hold.
- Simultaneous push and pop:
  - `ocupacion` unchanged; both pointers advance.
  - Legal at any non-full occupancy.
  - When full, `in_ready` is 0, so no same-cycle bypass.
- Empty queue: no bypass. A request accepted into an empty queue becomes head on the next cycle.
- `ocupacion` counts 0..PROFUNDIDAD inclusive. It never exceeds PROFUNDIDAD and never underflows.
- Reset mid-operation: all queued entries and the pending result are discarded. No partial result is emitted.

## Timing
- Reset values:
  - `res_valid`=0, `res_dato`=0, `res_sel`=0, `ocupacion`=0, `err_sel`=0
  - pointers 0
  - therefore `alu_enable`=0, `alu_*`=0, `in_ready`=1
- `in_ready`, `alu_*` and `alu_enable` are combinational from registered state only. `in_ready` does not depend on `in_valid` or `res_ready`.
- Latency, empty queue and idle output:
  - request accepted at edge E0
  - drives the ALU during cycle E0..E1
  - `res_valid`=1 after E1 (1 cycle)
- Throughput: 1 result/cycle while `res_ready` stays high and the queue is fed.
- `res_valid` held with `res_ready` low: `res_dato`/`res_sel` stable, no pop, queue fills, `in_ready` drops at `ocupacion == PROFUNDIDAD`.

## Configuration
- Macro: `ALU_COLA_CHECK_SEL_EN`.
- Defined:
  - a request with `in_sel` ∈ {101, 110} and `in_valid && in_ready` is not written
  - `err_sel` pulses 1 for the cycle after that edge
  - `ocupacion` unchanged by that request
  - the handshake still completes (request consumed)
- Undefined: all codes are enqueued (ALU yields 0 for 101/110), and `err_sel` is tied to 0.

## Test plan
- Reset, then push a=0x0000_0005, b=0x0000_0003, sel=010 with `res_ready`=1 -> `res_valid` one cycle after acceptance, `res_dato`=0x0000_0008, `res_sel`=010, then `res_valid`=0.
- Back-to-back pushes of sel 000, 001, 100, 011, 111 with a=0xF0F0_000C, b=0x0FF0_0004, `res_ready`=1 -> five consecutive results: 0x00F0_0004, 0xFFF0_000C, 0xFF0F_FFFB, 0xE100_0008, low 32 bits of the product; no bubbles.
- Hold `res_ready`=0, push PROFUNDIDAD+1 requests -> first result held stable, `ocupacion`=PROFUNDIDAD, `in_ready`=0; raise `res_ready` -> remaining results emerge in order and pointers wrap correctly.
- Full queue with `res_ready`=1 and `in_valid` held -> push/pop in the same cycle keeps `ocupacion` constant once `in_ready` returns; no entry lost or duplicated.
- Assert `rst_n`=0 asynchronously with 3 entries queued and `res_valid`=1 -> immediately `res_valid`=0, `ocupacion`=0, `alu_enable`=0, `in_ready`=1; no stale results after release.
- With `ALU_COLA_CHECK_SEL_EN`: push sel=101 -> `err_sel`=1 for one cycle, `ocupacion` stays 0, no result. Without the macro: the same push gives `res_dato`=0 and `err_sel`=0.
